// File: rtl/dm_arbiter_if.sv
// ============================================================================
// Module      : dm_arbiter_if
// Description : Bus bundle between the two data-memory requesters (port A =
//               pipeline MEM stage, port B = loader/debug), the arbiter and
//               the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_arbiter_if;
    // Port A request side
    logic        req_a;
    logic        we_a;
    logic [31:0] addr_a;
    logic [31:0] wdata_a;
    logic [1:0]  ls_bit_a;
    logic        ext_op_a;
    // Port A response side
    logic        gnt_a;
    logic        ack_a;
    logic        err_a;
    logic [31:0] rdata_a;
    logic        stall_a;

    // Port B request side
    logic        req_b;
    logic        we_b;
    logic [31:0] addr_b;
    logic [31:0] wdata_b;
    logic [1:0]  ls_bit_b;
    logic        ext_op_b;
    logic        lock_b;
    // Port B response side
    logic        gnt_b;
    logic        ack_b;
    logic        err_b;
    logic [31:0] rdata_b;

    // Memory side
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_ls_bit;
    logic        mem_ext_op;
    logic [31:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  req_a, we_a, addr_a, wdata_a, ls_bit_a, ext_op_a,
        output gnt_a, ack_a, err_a, rdata_a, stall_a,
        input  req_b, we_b, addr_b, wdata_b, ls_bit_b, ext_op_b, lock_b,
        output gnt_b, ack_b, err_b, rdata_b,
        output mem_we, mem_addr, mem_wdata, mem_ls_bit, mem_ext_op,
        input  mem_rdata
    );

    // Requester / memory view
    modport master (
        output req_a, we_a, addr_a, wdata_a, ls_bit_a, ext_op_a,
        input  gnt_a, ack_a, err_a, rdata_a, stall_a,
        output req_b, we_b, addr_b, wdata_b, ls_bit_b, ext_op_b, lock_b,
        input  gnt_b, ack_b, err_b, rdata_b,
        input  mem_we, mem_addr, mem_wdata, mem_ls_bit, mem_ext_op,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module      : dm_arbiter
// Description : Two-port data-memory arbiter. Port A has default priority,
//               port B is protected against starvation and may lock the
//               memory for bounded bursts. Misaligned / out-of-range
//               requests are granted but answered with an error ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  wire logic    clock,
    input  wire logic    reset_n,
    dm_arbiter_if.slave  bus
);

    localparam int C_SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int C_BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(STARVE_LIMIT);
    localparam logic [C_BW-1:0] C_BURST_MAX  = C_BW'(MAX_BURST);
    localparam logic [C_BW-1:0] C_BURST_ONE  = C_BW'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_BURST_B = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [C_SW-1:0] r_starve_cnt;
    logic [C_SW-1:0] w_starve_next;
    logic [C_BW-1:0] r_burst_cnt;
    logic [C_BW-1:0] w_burst_next;
    logic [C_BW-1:0] w_beats;
    logic            r_a_prio;
    logic            w_a_prio_next;

    logic            w_gnt_a_raw;
    logic            w_gnt_b_raw;
    logic            w_gnt_a;
    logic            w_gnt_b;
    logic            w_bad_a;
    logic            w_bad_b;

    logic            r_ack_a;
    logic            r_err_a;
    logic [31:0]     r_rdata_a;
    logic            r_ack_b;
    logic            r_err_b;
    logic [31:0]     r_rdata_b;

    // A request is rejected if it leaves the 4 KB window, uses the illegal
    // size code, or is not naturally aligned for its size.
    function automatic logic f_bad(input logic [31:0] addr, input logic [1:0] ls);
        f_bad = (addr[31:12] != 20'd0)
             || (ls == 2'b11)
             || ((ls == 2'b00) && (addr[1:0] != 2'b00))
             || ((ls == 2'b01) && addr[0]);
    endfunction

    assign w_bad_a = f_bad(bus.addr_a, bus.ls_bit_a);
    assign w_bad_b = f_bad(bus.addr_b, bus.ls_bit_b);

    // Grant selection and burst FSM next-state
    always_comb begin
        w_gnt_a_raw   = 1'b0;
        w_gnt_b_raw   = 1'b0;
        w_state_next  = r_state;
        w_burst_next  = r_burst_cnt;
        w_a_prio_next = 1'b0;
        w_beats       = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                // B wins when A is absent, or when B has starved long enough
                // and A was not just robbed by a maximal burst.
                if (bus.req_b && (!bus.req_a ||
                    ((r_starve_cnt == C_STARVE_MAX) && !r_a_prio))) begin
                    w_gnt_b_raw = 1'b1;
                end else begin
                    w_gnt_a_raw = bus.req_a;
                end
                w_burst_next = '0;
                if (w_gnt_b_raw && bus.lock_b) begin
                    if (C_BURST_ONE < C_BURST_MAX) begin
                        w_state_next = ST_BURST_B;
                        w_burst_next = C_BURST_ONE;
                    end else begin
                        // A one-beat burst is already complete.
                        w_a_prio_next = 1'b1;
                    end
                end
            end
            ST_BURST_B: begin
                w_gnt_b_raw = bus.req_b;
                w_beats     = r_burst_cnt + (bus.req_b ? C_BURST_ONE : '0);
                if (bus.req_b && bus.lock_b && (w_beats < C_BURST_MAX)) begin
                    w_burst_next = w_beats;
                end else begin
                    w_state_next  = ST_IDLE;
                    w_burst_next  = '0;
                    w_a_prio_next = (w_beats == C_BURST_MAX);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_burst_next = '0;
            end
        endcase
    end

    // No grant may leave the arbiter while reset is held.
    assign w_gnt_a = w_gnt_a_raw & reset_n;
    assign w_gnt_b = w_gnt_b_raw & reset_n;

    // Starvation counter: counts waiting cycles of B, saturating
    always_comb begin
        w_starve_next = '0;
        if (bus.req_b && !w_gnt_b_raw) begin
            w_starve_next = (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt
                                                           : r_starve_cnt + C_SW'(1);
        end
    end

    // Route the granted port onto the memory bus; rejected requests never write
    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_ls_bit = 2'b00;
        bus.mem_ext_op = 1'b0;
        if (w_gnt_a) begin
            bus.mem_we     = bus.we_a & ~w_bad_a;
            bus.mem_addr   = bus.addr_a;
            bus.mem_wdata  = bus.wdata_a;
            bus.mem_ls_bit = bus.ls_bit_a;
            bus.mem_ext_op = bus.ext_op_a;
        end else if (w_gnt_b) begin
            bus.mem_we     = bus.we_b & ~w_bad_b;
            bus.mem_addr   = bus.addr_b;
            bus.mem_wdata  = bus.wdata_b;
            bus.mem_ls_bit = bus.ls_bit_b;
            bus.mem_ext_op = bus.ext_op_b;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_a_prio     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_burst_cnt  <= w_burst_next;
            r_a_prio     <= w_a_prio_next;
        end
    end

    // Response registers: one-cycle ack/err pulse following each grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_a   <= 1'b0;
            r_err_a   <= 1'b0;
            r_rdata_a <= 32'd0;
            r_ack_b   <= 1'b0;
            r_err_b   <= 1'b0;
            r_rdata_b <= 32'd0;
        end else begin
            r_ack_a   <= w_gnt_a;
            r_err_a   <= w_gnt_a & w_bad_a;
            r_rdata_a <= (w_gnt_a && !w_bad_a && !bus.we_a) ? bus.mem_rdata : 32'd0;
            r_ack_b   <= w_gnt_b;
            r_err_b   <= w_gnt_b & w_bad_b;
            r_rdata_b <= (w_gnt_b && !w_bad_b && !bus.we_b) ? bus.mem_rdata : 32'd0;
        end
    end

    assign bus.gnt_a   = w_gnt_a;
    assign bus.gnt_b   = w_gnt_b;
    assign bus.stall_a = bus.req_a & ~w_gnt_a;
    assign bus.ack_a   = r_ack_a;
    assign bus.err_a   = r_err_a;
    assign bus.rdata_a = r_rdata_a;
    assign bus.ack_b   = r_ack_b;
    assign bus.err_b   = r_err_b;
    assign bus.rdata_b = r_rdata_b;

endmodule

`default_nettype wire
